// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding, field
// extraction helpers and the shift-op predicate.
package ctrl_pkg;

  // Default position of the arithmetic/move select bit inside the opcode.
  localparam int ARITH_BIT_DEFAULT = 3;

  // Helpers operate on a zero-extended word so one function serves any INSTR_W.
  localparam int WORD_MAX = 32;
  typedef logic [WORD_MAX-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    MOVE   = 2'd3
  } ctrl_state_t;

  function automatic word_t opcode_of(word_t ir, int instr_w, int opc_w);
    word_t mask;
    mask = (word_t'(1) << opc_w) - word_t'(1);
    return (ir >> (instr_w - opc_w)) & mask;
  endfunction

  function automatic word_t operand_of(word_t ir, int instr_w, int opc_w);
    word_t mask;
    mask = (word_t'(1) << (instr_w - opc_w)) - word_t'(1);
    return ir & mask;
  endfunction

  function automatic logic is_shift_op(logic [2:0] alu_op);
    return alu_op[2];
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Fetch handshake plus ALU / register-file control bundle of the controller.
interface ctrl_seq_if #(
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 4,
  parameter int SHAMT_W = 3
);
  logic                     instr_valid;
  logic [INSTR_W-1:0]       instr;
  logic                     instr_ready;
  logic                     stall;
  logic [2:0]               alu_op;
  logic [SHAMT_W-1:0]       alu_shamt;
  logic                     alu_en;
  logic                     reg_we;
  logic [INSTR_W-OPC_W-1:0] reg_sel;
  logic [1:0]               reg16_src;
  logic [1:0]               reg16_dst;
  logic                     busy;

  modport master (
    output instr_valid, instr, stall,
    input  instr_ready, alu_op, alu_shamt, alu_en, reg_we,
           reg_sel, reg16_src, reg16_dst, busy
  );

  modport slave (
    input  instr_valid, instr, stall,
    output instr_ready, alu_op, alu_shamt, alu_en, reg_we,
           reg_sel, reg16_src, reg16_dst, busy
  );
endinterface

// File: rtl/ctrl_seq_step_cnt.sv
// Loadable down-counter for shift steps; holds unless loaded or decremented.
module ctrl_step_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         last,
  output logic         zero
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign last = (count_reg == W'(1));
  assign zero = (count_reg == '0);
endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle controller: latches an instruction, then sequences it through
// FETCH / DECODE / EXEC / MOVE, issuing gated ALU and register-write strobes.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int INSTR_W    = 8,
  parameter int OPC_W      = 4,
  parameter int ARITH_BIT  = ARITH_BIT_DEFAULT,
  parameter int SHAMT_W    = 3,
  parameter int ITER_SHIFT = 1
) (
  input logic       clk,
  input logic       rst,
  ctrl_seq_if.slave bus
);

  generate
    if (INSTR_W - OPC_W < 4) begin : g_bad_operand
      $error("ctrl_seq: operand field must be at least 4 bits");
    end
    if (SHAMT_W > INSTR_W - OPC_W) begin : g_bad_shamt
      $error("ctrl_seq: SHAMT_W exceeds operand width");
    end
    if (ARITH_BIT >= OPC_W) begin : g_bad_arith
      $error("ctrl_seq: ARITH_BIT outside opcode");
    end
    if (OPC_W < 3) begin : g_bad_opc
      $error("ctrl_seq: opcode must hold a 3-bit ALU op");
    end
    if (INSTR_W > WORD_MAX) begin : g_bad_width
      $error("ctrl_seq: INSTR_W wider than helper word");
    end
  endgenerate

  ctrl_state_t              state_reg;
  logic [INSTR_W-1:0]       ir_reg;
  logic [OPC_W-1:0]         opcode;
  logic [INSTR_W-OPC_W-1:0] operand;
  logic [2:0]               op3;
  logic [SHAMT_W-1:0]       shamt_field;
  logic                     is_move;
  logic                     iter_mode;
  logic                     cnt_last;
  logic                     cnt_zero;
  logic                     step_done;

  assign opcode      = OPC_W'(opcode_of(word_t'(ir_reg), INSTR_W, OPC_W));
  assign operand     = (INSTR_W-OPC_W)'(operand_of(word_t'(ir_reg), INSTR_W, OPC_W));
  assign op3         = opcode[2:0];
  assign shamt_field = ir_reg[SHAMT_W-1:0];
  assign is_move     = opcode[ARITH_BIT];
  assign iter_mode   = (ITER_SHIFT != 0) && is_shift_op(op3);

  // A zero shamt still issues one step, so zero ends EXEC just like last.
  assign step_done = !iter_mode || cnt_last || cnt_zero;

  ctrl_step_cnt #(.W(SHAMT_W)) u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state_reg == DECODE),
    .dec      ((state_reg == EXEC) && !bus.stall && iter_mode && !cnt_zero),
    .load_val (shamt_field),
    .last     (cnt_last),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= FETCH;
      ir_reg    <= '0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (bus.instr_valid) begin
            ir_reg    <= bus.instr;
            state_reg <= DECODE;
          end
        end
        DECODE:  state_reg <= is_move ? MOVE : EXEC;
        EXEC:    if (!bus.stall && step_done) state_reg <= FETCH;
        MOVE:    if (!bus.stall) state_reg <= FETCH;
        default: state_reg <= FETCH;
      endcase
    end
  end

  // instr_ready is gated by rst because FETCH is also the reset state.
  assign bus.instr_ready = rst && (state_reg == FETCH);
  assign bus.busy        = (state_reg != FETCH);
  assign bus.alu_en      = (state_reg == EXEC) && !bus.stall;
  assign bus.reg_we      = (state_reg == MOVE) && !bus.stall;

  assign bus.alu_op    = op3;
  assign bus.alu_shamt = iter_mode ? (cnt_zero ? '0 : SHAMT_W'(1)) : shamt_field;
  assign bus.reg_sel   = operand;
  assign bus.reg16_src = operand[3:2];
  assign bus.reg16_dst = operand[1:0];

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomised bench for ctrl_seq: two instances (iterative and single-step
// shifts) checked against a transaction-level model of step counts and timing.
module tb_ctrl_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ctrl_seq_if #(.INSTR_W(8), .OPC_W(4), .SHAMT_W(3)) b1 ();
  ctrl_seq_if #(.INSTR_W(8), .OPC_W(4), .SHAMT_W(3)) b0 ();

  ctrl_seq #(.INSTR_W(8), .OPC_W(4), .ARITH_BIT(3), .SHAMT_W(3), .ITER_SHIFT(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  ctrl_seq #(.INSTR_W(8), .OPC_W(4), .ARITH_BIT(3), .SHAMT_W(3), .ITER_SHIFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0));

  bit         sel = 1'b1;
  logic       drv_valid = 1'b0;
  logic [7:0] drv_instr = 8'h00;
  logic       drv_stall = 1'b0;

  assign b1.instr_valid = drv_valid & sel;
  assign b0.instr_valid = drv_valid & ~sel;
  assign b1.instr = drv_instr;
  assign b0.instr = drv_instr;
  assign b1.stall = drv_stall;
  assign b0.stall = drv_stall;

  logic       m_ready, m_en, m_we, m_busy;
  logic [2:0] m_op, m_shamt;
  logic [3:0] m_sel;
  logic [1:0] m_src, m_dst;

  assign m_ready = sel ? b1.instr_ready : b0.instr_ready;
  assign m_en    = sel ? b1.alu_en      : b0.alu_en;
  assign m_we    = sel ? b1.reg_we      : b0.reg_we;
  assign m_busy  = sel ? b1.busy        : b0.busy;
  assign m_op    = sel ? b1.alu_op      : b0.alu_op;
  assign m_shamt = sel ? b1.alu_shamt   : b0.alu_shamt;
  assign m_sel   = sel ? b1.reg_sel     : b0.reg_sel;
  assign m_src   = sel ? b1.reg16_src   : b0.reg16_src;
  assign m_dst   = sel ? b1.reg16_dst   : b0.reg16_dst;

  int n_cmp = 0;
  int n_bad = 0;

  // Caller must be in the low half of the clock with the selected DUT in FETCH.
  // mask bit i stalls busy cycle i (cycle 0 is the decode cycle).
  task automatic run_txn(input bit use_iter, input logic [7:0] instr,
                         input logic [31:0] mask, input bit junk);
    int         exp_alu, exp_we, exp_cycles, remaining, cyc;
    logic [2:0] exp_shamt;
    int         got_alu, got_we, cycles;
    bit         done;

    exp_shamt = instr[2:0];
    exp_alu = 0;
    exp_we  = 0;
    if (instr[7]) begin
      exp_we = 1;
    end else if (use_iter && instr[6]) begin
      exp_alu   = (instr[2:0] == 3'd0) ? 1 : int'(instr[2:0]);
      exp_shamt = (instr[2:0] == 3'd0) ? 3'd0 : 3'd1;
    end else begin
      exp_alu = 1;
    end
    remaining = exp_alu + exp_we;
    cyc = 1;
    while (remaining > 0) begin
      if (!(cyc < 32 && mask[cyc])) remaining--;
      cyc++;
    end
    exp_cycles = cyc;

    sel = use_iter;
    drv_instr = instr;
    drv_valid = 1'b1;
    drv_stall = 1'b0;
    #1;
    n_cmp++;
    if (m_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_idle: got %b want 1", m_ready);
    end
    @(negedge clk);
    got_alu = 0;
    got_we  = 0;
    cycles  = 0;
    done    = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      drv_stall = (i < 32) ? mask[i] : 1'b0;
      drv_valid = junk;
      drv_instr = junk ? 8'($urandom) : instr;
      #1;
      if (m_ready === 1'b1) begin
        done = 1'b1;
        cycles = i;
      end else begin
        n_cmp++;
        if (m_busy !== 1'b1) begin
          n_bad++;
          $display("FAIL busy: cycle %0d got %b want 1", i, m_busy);
        end
        n_cmp++;
        if (((m_en | m_we) & drv_stall) !== 1'b0) begin
          n_bad++;
          $display("FAIL strobe_in_stall: cycle %0d alu_en=%b reg_we=%b want 0", i, m_en, m_we);
        end
        if (m_en === 1'b1) begin
          got_alu++;
          n_cmp++;
          if (m_op !== instr[6:4] || m_shamt !== exp_shamt) begin
            n_bad++;
            $display("FAIL alu_fields: got op=%0d shamt=%0d want op=%0d shamt=%0d",
                     m_op, m_shamt, instr[6:4], exp_shamt);
          end
        end
        if (m_we === 1'b1) begin
          got_we++;
          n_cmp++;
          if ({m_src, m_dst} !== instr[3:0] || m_sel !== instr[3:0]) begin
            n_bad++;
            $display("FAIL move_fields: got src=%0d dst=%0d sel=%h want src=%0d dst=%0d sel=%h",
                     m_src, m_dst, m_sel, instr[3:2], instr[1:0], instr[3:0]);
          end
        end
        @(negedge clk);
      end
    end
    drv_valid = 1'b0;
    drv_stall = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL timeout: instr=%h never returned to ready", instr);
    end
    n_cmp++;
    if (cycles !== exp_cycles) begin
      n_bad++;
      $display("FAIL latency: instr=%h got %0d busy cycles want %0d", instr, cycles, exp_cycles);
    end
    n_cmp++;
    if (got_alu !== exp_alu || got_we !== exp_we) begin
      n_bad++;
      $display("FAIL strobe_count: instr=%h got alu=%0d we=%0d want alu=%0d we=%0d",
               instr, got_alu, got_we, exp_alu, exp_we);
    end
    $display("txn iter=%0d instr=%h mask=%h cycles=%0d alu_pulses=%0d we_pulses=%0d",
             use_iter, instr, mask, cycles, got_alu, got_we);
  endtask

  task automatic test_reset;
    drv_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({b1.instr_ready, b1.busy, b1.alu_en, b1.reg_we,
         b0.instr_ready, b0.busy, b0.alu_en, b0.reg_we} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_held: got ready/busy/en/we=%b%b%b%b %b%b%b%b want all 0",
               b1.instr_ready, b1.busy, b1.alu_en, b1.reg_we,
               b0.instr_ready, b0.busy, b0.alu_en, b0.reg_we);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (b1.instr_ready !== 1'b1 || b1.busy !== 1'b0 || b0.instr_ready !== 1'b1 || b0.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got ready=%b%b busy=%b%b want ready=11 busy=00",
               b1.instr_ready, b0.instr_ready, b1.busy, b0.busy);
    end
    n_cmp++;
    if (b1.alu_op !== 3'd0 || b1.reg_sel !== 4'd0 || b1.alu_shamt !== 3'd0 || b1.alu_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ir: got op=%0d sel=%h shamt=%0d en=%b want 0 0 0 0",
               b1.alu_op, b1.reg_sel, b1.alu_shamt, b1.alu_en);
    end
  endtask

  task automatic test_arith;
    run_txn(1'b1, 8'h05, 32'h0, 1'b0);
    run_txn(1'b0, 8'h05, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) run_txn(1'b1, {1'b0, 3'($urandom_range(0, 3)), 4'($urandom)}, 32'h0, 1'b0);
  endtask

  task automatic test_shift;
    run_txn(1'b1, 8'h43, 32'h0, 1'b0);
    run_txn(1'b1, 8'h40, 32'h0, 1'b0);
    run_txn(1'b0, 8'h43, 32'h0, 1'b0);
    run_txn(1'b1, 8'h77, 32'h0, 1'b0);
  endtask

  task automatic test_move;
    run_txn(1'b1, 8'h8E, 32'h0, 1'b0);
    run_txn(1'b0, 8'hF1, 32'h0, 1'b0);
  endtask

  task automatic test_stall;
    run_txn(1'b1, 8'h42, 32'h6, 1'b0);
    run_txn(1'b1, 8'h9B, 32'h7, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++)
      run_txn(1'($urandom), 8'($urandom), $urandom & $urandom, 1'($urandom));
  endtask

  task automatic test_reset_mid;
    int pulses;
    @(negedge clk);
    sel = 1'b1;
    drv_instr = 8'h47;
    drv_valid = 1'b1;
    drv_stall = 1'b0;
    @(negedge clk);
    drv_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10 && pulses < 2; i++) begin
      #1;
      if (m_en === 1'b1) pulses++;
      if (pulses < 2) @(negedge clk);
    end
    n_cmp++;
    if (pulses !== 2) begin
      n_bad++;
      $display("FAIL mid_pulses: got %0d want 2", pulses);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({m_en, m_we, m_ready, m_busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_reset: got en/we/ready/busy=%b%b%b%b want 0000", m_en, m_we, m_ready, m_busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ((m_en | m_we) !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_quiet: cycle %0d en=%b we=%b want 0", i, m_en, m_we);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (m_ready !== 1'b1 || m_op !== 3'd0 || m_sel !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_release: got ready=%b op=%0d sel=%h want 1 0 0", m_ready, m_op, m_sel);
    end
    run_txn(1'b1, 8'h01, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_move();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
